if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC, computes the next fetch address from the control decoder's SEL_DIR code (PC+4 / j / jr), and runs a req/ack handshake with instruction memory. It also owns the IF/ID pipeline register that feeds opcode/funct to the decoder, with flush (resetIF) and hazard-stall support.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_fetch_stage_if_id_reg.sv | 36 +++
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 tb/tb_if_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, next-PC select codes and the NOP word.
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DROP,
        S_HOLD
    } if_state_e;

    localparam logic [1:0] DIR_PC4 = 2'b00;
    localparam logic [1:0] DIR_J   = 2'b01;
    localparam logic [1:0] DIR_JR  = 2'b10;

    // sll $0,$0,0
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] j_target(
        input logic [31:0] pc4,
        input logic [31:0] instr
    );
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register (instruction, PC+4, valid).
// Ports: clk, rst_n, load, flush, instr_in, pc4_in -> instr, pc4, valid.
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // flush beats load; neither means hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, next-PC select, imem req/ack handshake and IF/ID reg.
// Ports: clk, rst_n, stall_id, sel_dir, flush_id, jr_target, imem_* , *_id, pc_if.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic [1:0]  sel_dir,
    input  logic        flush_id,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic [31:0] pc_if
);

    if_state_e   state;
    logic [31:0] fetch_addr;
    logic [31:0] pc_pend;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;

    logic        redir;
    logic [31:0] target;
    logic [31:0] addr_inc;
    logic        idr_load;
    logic        idr_flush;
    logic [31:0] idr_instr;
    logic [31:0] idr_pc4;

    // stall masks any redirect; code 11 behaves as PC+4
    assign redir = ((sel_dir == DIR_J) || (sel_dir == DIR_JR)) & ~stall_id;

    // jr target is word-aligned so imem_addr[1:0] stays 00
    assign target = (sel_dir == DIR_J)
                  ? j_target(pc4_id, instr_id)
                  : (jr_target & ~32'h3);

    assign addr_inc  = fetch_addr + 32'd4;
    assign imem_req  = (state == S_FETCH) || (state == S_DROP);
    assign imem_addr = fetch_addr;
    assign pc_if     = (state == S_DROP) ? pc_pend : fetch_addr;

    always_comb begin
        idr_flush = ~stall_id & (flush_id | ((state == S_HOLD) & redir));
        idr_load  = 1'b0;
        idr_instr = imem_rdata;
        idr_pc4   = addr_inc;
        unique case (state)
            S_FETCH: idr_load = imem_ack & ~redir & ~stall_id;
            S_HOLD: begin
                idr_load  = ~stall_id & ~redir;
                idr_instr = buf_instr;
                idr_pc4   = buf_pc4;
            end
            S_IDLE, S_DROP: idr_load = 1'b0;
            default: idr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fetch_addr <= RESET_PC;
            pc_pend    <= '0;
            buf_instr  <= '0;
            buf_pc4    <= '0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redir) begin
                            fetch_addr <= target;
                        end else begin
                            fetch_addr <= addr_inc;
                            if (stall_id) begin
                                buf_instr <= imem_rdata;
                                buf_pc4   <= addr_inc;
                                state     <= S_HOLD;
                            end
                        end
                    end else if (redir) begin
                        // request is in flight: let it finish, then jump
                        pc_pend <= target;
                        state   <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (redir) pc_pend <= target;
                    if (imem_ack) begin
                        fetch_addr <= redir ? target : pc_pend;
                        state      <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (!stall_id) begin
                        if (redir) fetch_addr <= target;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (idr_load),
        .flush    (idr_flush),
        .instr_in (idr_instr),
        .pc4_in   (idr_pc4),
        .instr    (instr_id),
        .pc4      (pc4_id),
        .valid    (valid_id)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized bench for if_fetch_stage.
// Memory model with random wait states plus a behavioural fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_id = 1'b0;
    logic [1:0]  sel_dir = 2'b00;
    logic        flush_id = 1'b0;
    logic [31:0] jr_target = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic [31:0] pc_if;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_id   (stall_id),
        .sel_dir    (sel_dir),
        .flush_id   (flush_id),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_id   (instr_id),
        .pc4_id     (pc4_id),
        .valid_id   (valid_id),
        .pc_if      (pc_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // behavioural model of the fetch stage
    logic        m_run, m_hold, m_drop, m_valid;
    logic [31:0] m_addr, m_pend, m_bi, m_bp, m_instr, m_pc4;
    int          wcnt, wait_lo, wait_hi;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_000C) ? 32'h0800_0040 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic put_nop();
        m_instr = NOP;
        m_pc4   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_run = 0; m_hold = 0; m_drop = 0; m_valid = 0;
        m_addr = '0; m_pend = '0; m_bi = '0; m_bp = '0;
        m_instr = NOP; m_pc4 = '0;
        wcnt = $urandom_range(wait_hi, wait_lo);
    endtask

    task automatic check_outs();
        check("req",   {31'd0, imem_req}, {31'd0, m_run & ~m_hold});
        check("addr",  imem_addr, m_addr);
        check("pc_if", pc_if, m_drop ? m_pend : m_addr);
        check("instr", instr_id, m_instr);
        check("pc4",   pc4_id, m_pc4);
        check("valid", {31'd0, valid_id}, {31'd0, m_valid});
    endtask

    task automatic model_step(input logic st, input logic [1:0] sd,
                              input logic fl, input logic [31:0] jt,
                              input logic ack);
        logic        rd;
        logic [31:0] tg, mw;
        rd = ((sd == 2'b01) || (sd == 2'b10)) && !st;
        tg = (sd == 2'b01) ? {m_pc4[31:28], m_instr[25:0], 2'b00}
                           : {jt[31:2], 2'b00};
        mw = mem_word(m_addr);
        if (!m_run) begin
            m_run = 1'b1;
            if (fl && !st) put_nop();
        end else if (m_hold) begin
            if (!st) begin
                m_hold = 1'b0;
                if (rd) begin
                    m_addr = tg;
                    put_nop();
                end else if (fl) begin
                    put_nop();
                end else begin
                    m_instr = m_bi; m_pc4 = m_bp; m_valid = 1'b1;
                end
            end
        end else if (m_drop) begin
            if (rd) m_pend = tg;
            if (ack) begin
                m_addr = m_pend;
                m_drop = 1'b0;
            end
            if (fl && !st) put_nop();
        end else begin
            if (ack && rd) begin
                m_addr = tg;
            end else if (ack && st) begin
                m_bi = mw; m_bp = m_addr + 32'd4;
                m_addr = m_addr + 32'd4;
                m_hold = 1'b1;
            end else if (ack) begin
                m_instr = mw; m_pc4 = m_addr + 32'd4; m_valid = 1'b1;
                m_addr = m_addr + 32'd4;
            end else if (rd) begin
                m_pend = tg;
                m_drop = 1'b1;
            end
            if (fl && !st) put_nop();
        end
    endtask

    // one clock: check, drive, advance model, move to next negedge
    task automatic cycle(input logic st, input logic [1:0] sd,
                         input logic fl, input logic [31:0] jt);
        logic req, ack;
        check_outs();
        stall_id = st; sel_dir = sd; flush_id = fl; jr_target = jt;
        req = m_run & ~m_hold;
        ack = req && (wcnt == 0);
        imem_ack = ack;
        imem_rdata = ack ? mem_word(m_addr) : 32'hDEAD_BEEF;
        model_step(st, sd, fl, jt, ack);
        if (ack) wcnt = $urandom_range(wait_hi, wait_lo);
        else if (req) wcnt--;
        @(negedge clk);
    endtask

    task automatic wait_fresh_req(input string tag);
        int n = 0;
        while (!(m_run && !m_hold && !m_drop && wcnt == 2) && n < 20) begin
            cycle(1'b0, 2'b00, 1'b0, '0);
            n++;
        end
        check(tag, {31'd0, (n < 20)}, 32'd1);
    endtask

    initial begin
        logic [31:0] saved, old_addr;
        int          n;
        logic        st, fl;
        logic [1:0]  sd;
        logic [31:0] jt;
        int          r;

        wait_lo = 0; wait_hi = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // zero-wait streaming from reset
        cycle(1'b0, 2'b00, 1'b0, '0);
        cycle(1'b0, 2'b00, 1'b0, '0);
        check("first_instr", instr_id, 32'hA5A5_0000);
        check("first_pc4",   pc4_id,   32'h0000_0004);
        cycle(1'b0, 2'b00, 1'b0, '0);
        check("second_instr", instr_id, 32'hA5A5_0004);
        check("second_pc4",   pc4_id,   32'h0000_0008);

        // j from IF/ID word 0x0800_0040 at pc4 0x10
        n = 0;
        while (m_instr != 32'h0800_0040 && n < 10) begin
            cycle(1'b0, 2'b00, 1'b0, '0);
            n++;
        end
        check("j_setup", instr_id, 32'h0800_0040);
        check("j_setup_pc4", pc4_id, 32'h0000_0010);
        cycle(1'b0, 2'b01, 1'b1, '0);
        check("j_addr",  imem_addr, 32'h0000_0100);
        check("j_valid", {31'd0, valid_id}, 32'd0);
        check("j_instr", instr_id, NOP);

        // 3-cycle stall coincident with an ack
        saved = instr_id;
        cycle(1'b1, 2'b00, 1'b0, '0);
        check("hold_noreq", {31'd0, imem_req}, 32'd0);
        cycle(1'b1, 2'b00, 1'b0, '0);
        cycle(1'b1, 2'b00, 1'b0, '0);
        check("hold_instr", instr_id, saved);
        cycle(1'b0, 2'b00, 1'b0, '0);
        check("release_instr", instr_id, 32'hA5A5_0100);
        check("release_pc4",   pc4_id,   32'h0000_0104);
        cycle(1'b0, 2'b00, 1'b0, '0);
        check("after_release", instr_id, 32'hA5A5_0104);

        // jr mid-request with 2 wait states
        wait_lo = 2; wait_hi = 2;
        wait_fresh_req("drop_setup");
        old_addr = m_addr;
        cycle(1'b0, 2'b10, 1'b1, 32'h0000_0200);
        check("drop_addr_held", imem_addr, old_addr);
        check("drop_pc_if", pc_if, 32'h0000_0200);
        n = 0;
        while (m_drop && n < 10) begin
            cycle(1'b0, 2'b00, 1'b0, '0);
            n++;
        end
        check("drop_new_addr", imem_addr, 32'h0000_0200);
        check("drop_discard", {31'd0, valid_id}, 32'd0);

        // stalled jr only takes effect once unstalled
        wait_lo = 0; wait_hi = 0;
        wcnt = 0;
        cycle(1'b0, 2'b00, 1'b0, '0);
        saved = instr_id;
        cycle(1'b1, 2'b10, 1'b1, 32'h0000_0400);
        cycle(1'b1, 2'b10, 1'b1, 32'h0000_0400);
        check("stall_jr_instr", instr_id, saved);
        check("stall_jr_pc", {31'd0, (imem_addr == 32'h400)}, 32'd0);
        cycle(1'b0, 2'b10, 1'b1, 32'h0000_0400);
        check("stall_jr_addr", imem_addr, 32'h0000_0400);

        // randomized traffic
        wait_lo = 0; wait_hi = 2;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 4) == 0);
            r  = $urandom_range(0, 11);
            sd = (r == 0) ? 2'b01 : (r == 1 || r == 2) ? 2'b10 :
                 (r == 3) ? 2'b11 : 2'b00;
            fl = (sd == 2'b01) || (sd == 2'b10);
            r  = $urandom_range(0, 7);
            jt = (r == 0) ? 32'hFFFF_FFF8 : (r == 1) ? 32'($urandom()) :
                 32'($urandom_range(0, 1023)) << 2;
            cycle(st, sd, fl, jt);
        end

        // async reset while in S_DROP
        wait_lo = 2; wait_hi = 2;
        wait_fresh_req("rst_setup");
        cycle(1'b0, 2'b10, 1'b1, 32'h0000_0300);
        check("rst_in_drop", {31'd0, m_drop}, 32'd1);
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b0; stall_id = 1'b0; sel_dir = 2'b00; flush_id = 1'b0;
        #1;
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_instr", instr_id, NOP);
        check("rst_pc4",   pc4_id, 32'd0);
        check("rst_valid", {31'd0, valid_id}, 32'd0);
        check("rst_pc_if", pc_if, 32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        wait_lo = 0; wait_hi = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 2'b00, 1'b0, '0);
        check("rst_first_req",  {31'd0, imem_req}, 32'd1);
        check("rst_first_addr", imem_addr, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'b00, 1'b0, '0);
        check_outs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
